user_bram_arbiter: RTL and testbench

Shares the single-port user-project data BRAM between the Wishbone host port and the FIR, matrix-multiply and quick-sort engines inside the user project. Requester 0 (Wishbone) gets priority at every arbitration point; engines 1..3 are served round-robin. A grant lasts for a burst. The block drives the BRAM port directly and routes read data back to the requester that issued each read.

---
 rtl/user_bram_arbiter_pkg.sv | 30 +++
 rtl/user_bram_arbiter_if.sv | 33 +++
 rtl/user_bram_arbiter_rr_picker.sv | 39 +++
 rtl/user_bram_arbiter.sv | 173 +++++++++++++++++
 tb/tb_user_bram_arbiter.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/user_bram_arbiter_pkg.sv
// Shared types and constants for the user-project BRAM arbiter.
package user_bram_arb_pkg;

    // Default widths and timing knobs
    localparam int N_REQ_DEF     = 4;
    localparam int ADDR_W_DEF    = 12;
    localparam int DATA_W_DEF    = 32;
    localparam int RD_LAT_DEF    = 1;
    localparam int MAX_BURST_DEF = 16;
    localparam int IDLE_TMO_DEF  = 8;

    // Requester indices; 0 is the Wishbone host and always has priority
    localparam int REQ_WB  = 0;
    localparam int REQ_FIR = 1;
    localparam int REQ_MM  = 2;
    localparam int REQ_QS  = 3;

    // Arbiter FSM encoding
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // Round-robin pointer after serving engine k: next engine, wrapping past
    // the last engine back to 1 (requester 0 never enters the rotation).
    function automatic int rr_after(input int k, input int n_req);
        return (k >= n_req - 1) ? 1 : k + 1;
    endfunction

endpackage

// File: rtl/user_bram_arbiter_if.sv
// Requester-side bus of the BRAM arbiter: packed per-requester beats plus the
// shared tagged read-response bus.
//
// Handshake: a beat from requester i transfers in a cycle where
// req_valid[i] && req_ready[i]. A requester holds valid and its payload
// stable until accepted. req_ready is one-hot or zero. rsp_valid is a
// one-hot, single-cycle notification with no back-pressure: rsp_rdata is
// meaningful only in that cycle and only for the flagged requester.
interface user_bram_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic [N_REQ-1:0]          req_valid;
    logic [N_REQ-1:0]          req_we;
    logic [N_REQ-1:0]          req_last;
    logic [N_REQ*ADDR_W-1:0]   req_addr;
    logic [N_REQ*DATA_W-1:0]   req_wdata;
    logic [N_REQ*DATA_W/8-1:0] req_wstrb;
    logic [N_REQ-1:0]          req_ready;
    logic [N_REQ-1:0]          rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;

    modport master (
        output req_valid, req_we, req_last, req_addr, req_wdata, req_wstrb,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_last, req_addr, req_wdata, req_wstrb,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/user_bram_arbiter_rr_picker.sv
// Combinational winner selection: requester 0 first, then engines
// 1..N_REQ-1 scanned cyclically starting at rr_ptr.
module rr_picker
    import user_bram_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] winner,
    output logic             found
);

    int start;
    int scan_idx;

    // Priority for the host, otherwise first valid engine at/after rr_ptr
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        scan_idx = 0;
        // A pointer of 0 never occurs in normal operation; treat it as 1
        start    = (rr_ptr == '0) ? 1 : int'(rr_ptr);
        if (valid[REQ_WB]) begin
            winner = IDX_W'(REQ_WB);
            found  = 1'b1;
        end else begin
            for (int k = 0; k < N_REQ - 1; k++) begin
                scan_idx = ((start - 1 + k) % (N_REQ - 1)) + 1;
                if (!found && valid[scan_idx]) begin
                    winner = IDX_W'(scan_idx);
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/user_bram_arbiter.sv
// Arbitrates the single-port user data BRAM between the Wishbone host and
// the FIR / matrix-multiply / quick-sort engines. Grants last a burst; read
// responses are tagged so they return to their issuer even across grants.
module user_bram_arbiter
    import user_bram_arb_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int RD_LAT    = RD_LAT_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF,
    parameter int IDLE_TMO  = IDLE_TMO_DEF,
    parameter int IDX_W     = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    user_bram_arbiter_if.slave    bus,
    output logic                  mem_en,
    output logic [DATA_W/8-1:0]   mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [IDX_W-1:0]      grant_id,
    output logic                  busy,
    output arb_state_t            dbg_state,
    output logic [IDX_W-1:0]      dbg_rr_ptr,
    output logic [$clog2(MAX_BURST+1)-1:0] dbg_beat_cnt
);

    localparam int STRB_W = DATA_W / 8;
    localparam int BCNT_W = $clog2(MAX_BURST + 1);
    localparam int TCNT_W = $clog2(IDLE_TMO + 1);

    arb_state_t          state;
    logic [IDX_W-1:0]    grant_q;
    logic [IDX_W-1:0]    rr_ptr;
    logic                busy_q;
    logic [BCNT_W-1:0]   beat_cnt;
    logic [TCNT_W-1:0]   idle_cnt;

    logic [IDX_W-1:0]    pick_winner;
    logic                pick_found;

    logic                g_valid;
    logic                g_we;
    logic                g_last;
    logic [ADDR_W-1:0]   g_addr;
    logic [DATA_W-1:0]   g_wdata;
    logic [STRB_W-1:0]   g_strb;
    logic                accept;
    logic                cap_hit;
    logic                tmo_hit;

    logic [RD_LAT-1:0]   pipe_v;
    logic [IDX_W-1:0]    pipe_tag [RD_LAT];

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .valid  (bus.req_valid),
        .rr_ptr (rr_ptr),
        .winner (pick_winner),
        .found  (pick_found)
    );

    // Select the current owner's beat and decide whether it transfers
    always_comb begin
        g_valid = bus.req_valid[grant_q];
        g_we    = bus.req_we[grant_q];
        g_last  = bus.req_last[grant_q];
        g_addr  = bus.req_addr[int'(grant_q)*ADDR_W +: ADDR_W];
        g_wdata = bus.req_wdata[int'(grant_q)*DATA_W +: DATA_W];
        g_strb  = bus.req_wstrb[int'(grant_q)*STRB_W +: STRB_W];
        accept  = (state == ST_GRANT) && g_valid;
        // beat_cnt holds beats already taken, so this beat is number MAX_BURST
        cap_hit = (beat_cnt == BCNT_W'(MAX_BURST - 1));
        tmo_hit = (idle_cnt == TCNT_W'(IDLE_TMO - 1));
    end

    // Ready to the owner only, and drive the BRAM port from the accepted beat
    always_comb begin
        bus.req_ready = '0;
        if (state == ST_GRANT) begin
            bus.req_ready[grant_q] = g_valid;
        end
        mem_en    = accept;
        mem_we    = (accept && g_we) ? g_strb : '0;
        mem_addr  = accept ? g_addr  : '0;
        mem_wdata = accept ? g_wdata : '0;
    end

    // Arbitration FSM with burst, cap and stall-timeout release
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr   <= IDX_W'(1);
            busy_q   <= 1'b0;
            beat_cnt <= '0;
            idle_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        state    <= ST_GRANT;
                        grant_q  <= pick_winner;
                        busy_q   <= 1'b1;
                        beat_cnt <= '0;
                        idle_cnt <= '0;
                        if (pick_winner != IDX_W'(REQ_WB)) begin
                            rr_ptr <= IDX_W'(rr_after(int'(pick_winner), N_REQ));
                        end
                    end
                end
                ST_GRANT: begin
                    if (accept) begin
                        idle_cnt <= '0;
                        if (g_last || cap_hit) begin
                            state    <= ST_IDLE;
                            busy_q   <= 1'b0;
                            beat_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end else if (tmo_hit) begin
                        state    <= ST_IDLE;
                        busy_q   <= 1'b0;
                        beat_cnt <= '0;
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Tag pipe: follows each accepted read through the BRAM latency
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_v <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_tag[i] <= '0;
            end
        end else begin
            pipe_v[0]   <= accept && !g_we;
            pipe_tag[0] <= grant_q;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_v[i]   <= pipe_v[i-1];
                pipe_tag[i] <= pipe_tag[i-1];
            end
        end
    end

    // Route BRAM read data to the requester that issued the read
    always_comb begin
        bus.rsp_valid = '0;
        bus.rsp_rdata = '0;
        if (pipe_v[RD_LAT-1]) begin
            bus.rsp_valid[pipe_tag[RD_LAT-1]] = 1'b1;
            bus.rsp_rdata                     = mem_rdata;
        end
    end

    assign grant_id     = grant_q;
    assign busy         = busy_q;
    assign dbg_state    = state;
    assign dbg_rr_ptr   = rr_ptr;
    assign dbg_beat_cnt = beat_cnt;

endmodule

// File: tb/tb_user_bram_arbiter.sv
// Directed bench for user_bram_arbiter with a 2-cycle BRAM model.
module tb_user_bram_arbiter;
    import user_bram_arb_pkg::*;

    localparam int N_REQ     = 4;
    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 32;
    localparam int RD_LAT    = 2;
    localparam int MAX_BURST = 16;
    localparam int IDLE_TMO  = 8;

    logic              clk;
    logic              rst_n;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [11:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic [1:0]        grant_id;
    logic              busy;
    arb_state_t        dbg_state;
    logic [1:0]        dbg_rr_ptr;
    logic [4:0]        dbg_beat_cnt;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    user_bram_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    user_bram_arbiter #(
        .N_REQ     (N_REQ),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .RD_LAT    (RD_LAT),
        .MAX_BURST (MAX_BURST),
        .IDLE_TMO  (IDLE_TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .grant_id     (grant_id),
        .busy         (busy),
        .dbg_state    (dbg_state),
        .dbg_rr_ptr   (dbg_rr_ptr),
        .dbg_beat_cnt (dbg_beat_cnt)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: byte-strobed writes, 2-cycle registered read
    logic [31:0] ram [0:4095];
    logic [31:0] rd_s1;
    logic [31:0] rd_s2;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we == 4'h0) begin
                rd_s1 <= ram[mem_addr];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_we[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                end
            end
        end
        rd_s2 <= rd_s1;
    end
    assign mem_rdata = rd_s2;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic we, input logic last,
                           input logic [11:0] a, input logic [31:0] d);
        bus.req_valid[i]          = v;
        bus.req_we[i]             = we;
        bus.req_last[i]           = last;
        bus.req_addr[i*12 +: 12]  = a;
        bus.req_wdata[i*32 +: 32] = d;
        bus.req_wstrb[i*4 +: 4]   = 4'hF;
    endtask

    task automatic drop(input int i);
        bus.req_valid[i] = 1'b0;
    endtask

    task automatic check_reset_values(input string p);
        check({p, "_ready"},    64'(bus.req_ready), 64'h0);
        check({p, "_rsp_v"},    64'(bus.rsp_valid), 64'h0);
        check({p, "_rsp_d"},    64'(bus.rsp_rdata), 64'h0);
        check({p, "_mem_en"},   64'(mem_en),        64'h0);
        check({p, "_mem_we"},   64'(mem_we),        64'h0);
        check({p, "_mem_addr"}, 64'(mem_addr),      64'h0);
        check({p, "_mem_wd"},   64'(mem_wdata),     64'h0);
        check({p, "_grant"},    64'(grant_id),      64'h0);
        check({p, "_busy"},     64'(busy),          64'h0);
        check({p, "_rr_ptr"},   64'(dbg_rr_ptr),    64'h1);
        check({p, "_beat"},     64'(dbg_beat_cnt),  64'h0);
        check({p, "_state"},    64'(dbg_state),     64'(ST_IDLE));
    endtask

    // One single-beat grant: owner seen this cycle, released and idle next
    task automatic rr_grant(input string tag, input int id, input logic [11:0] a);
        cyc(); settle();
        check({tag, "_grant"}, 64'(grant_id),      64'(id));
        check({tag, "_ready"}, 64'(bus.req_ready), 64'(1) << id);
        check({tag, "_addr"},  64'(mem_addr),      64'(a));
        cyc(); drop(id); settle();
        check({tag, "_dead"},  64'(busy),          64'h0);
    endtask

    initial begin
        // Reset
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_last  = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wstrb = '0;
        repeat (3) cyc();
        rst_n = 1'b1;
        settle();
        check_reset_values("rst");

        // Host writes 0x0000ABCD to 0x010, then reads it back
        set_req(0, 1, 1, 1, 12'h010, 32'h0000ABCD); settle();
        check("a_idle_ready", 64'(bus.req_ready), 64'h0);
        cyc(); settle();
        check("a_wr_ready", 64'(bus.req_ready), 64'h1);
        check("a_wr_we",    64'(mem_we),        64'hF);
        check("a_wr_addr",  64'(mem_addr),      64'h010);
        check("a_wr_data",  64'(mem_wdata),     64'h0000ABCD);
        check("a_wr_busy",  64'(busy),          64'h1);
        cyc(); set_req(0, 1, 0, 1, 12'h010, 32'h0); settle();
        check("a_dead_busy", 64'(busy),   64'h0);
        check("a_dead_en",   64'(mem_en), 64'h0);
        cyc(); settle();
        check("a_rd_ready", 64'(bus.req_ready), 64'h1);
        check("a_rd_en",    64'(mem_en),        64'h1);
        check("a_rd_we",    64'(mem_we),        64'h0);
        cyc(); drop(0); settle();
        check("a_rsp_early", 64'(bus.rsp_valid), 64'h0);
        cyc(); settle();
        check("a_rsp_valid", 64'(bus.rsp_valid), 64'h1);
        check("a_rsp_data",  64'(bus.rsp_rdata), 64'h0000ABCD);

        // Round-robin from rr_ptr=1: order 1,2,3
        set_req(1, 1, 1, 1, 12'h100, 32'h11111111);
        set_req(2, 1, 1, 1, 12'h200, 32'h22222222);
        set_req(3, 1, 1, 1, 12'h300, 32'h33333333);
        rr_grant("b_fir", 1, 12'h100);
        rr_grant("b_mm",  2, 12'h200);
        rr_grant("b_qs",  3, 12'h300);
        check("b_ptr_wrap", 64'(dbg_rr_ptr), 64'h1);

        // Serve MM alone to move rr_ptr to 3, then order 3,1,2
        set_req(2, 1, 1, 1, 12'h201, 32'h22222223);
        rr_grant("b_mm_only", 2, 12'h201);
        check("b_ptr3", 64'(dbg_rr_ptr), 64'h3);
        set_req(1, 1, 1, 1, 12'h101, 32'h11111112);
        set_req(2, 1, 1, 1, 12'h202, 32'h22222224);
        set_req(3, 1, 1, 1, 12'h301, 32'h33333334);
        rr_grant("b2_qs",  3, 12'h301);
        rr_grant("b2_fir", 1, 12'h101);
        rr_grant("b2_mm",  2, 12'h202);

        // Host waits for FIR's 4-beat burst, then beats pending MM
        set_req(1, 1, 1, 0, 12'h400, 32'hF0000000);
        cyc(); settle();
        check("c_b1_grant", 64'(grant_id), 64'h1);
        check("c_b1_addr",  64'(mem_addr), 64'h400);
        cyc();
        set_req(1, 1, 1, 0, 12'h401, 32'hF0000001);
        set_req(0, 1, 0, 1, 12'h010, 32'h0);
        set_req(2, 1, 1, 1, 12'h500, 32'h55555555);
        settle();
        check("c_b2_ready", 64'(bus.req_ready), 64'h2);
        check("c_b2_addr",  64'(mem_addr),      64'h401);
        cyc(); set_req(1, 1, 1, 0, 12'h402, 32'hF0000002); settle();
        check("c_b3_ready", 64'(bus.req_ready), 64'h2);
        cyc(); set_req(1, 1, 1, 1, 12'h403, 32'hF0000003); settle();
        check("c_b4_ready", 64'(bus.req_ready), 64'h2);
        check("c_b4_addr",  64'(mem_addr),      64'h403);
        cyc(); drop(1); settle();
        check("c_dead_busy", 64'(busy), 64'h0);
        cyc(); settle();
        check("c_wb_grant", 64'(grant_id),      64'h0);
        check("c_wb_ready", 64'(bus.req_ready), 64'h1);
        cyc(); drop(0); settle();
        check("c_dead2_busy", 64'(busy), 64'h0);
        cyc(); settle();
        check("c_mm_grant", 64'(grant_id),      64'h2);
        check("c_mm_ready", 64'(bus.req_ready), 64'h4);
        check("c_wb_rsp_v", 64'(bus.rsp_valid), 64'h1);
        check("c_wb_rsp_d", 64'(bus.rsp_rdata), 64'h0000ABCD);
        cyc(); drop(2); settle();
        check("c_end_busy", 64'(busy), 64'h0);

        // QS streams 20 beats; forced release after beat 16
        set_req(3, 1, 1, 0, 12'h600, 32'h600);
        for (int b = 1; b <= 20; b++) begin
            if (b == 17) begin
                cyc(); settle();
                check("d_dead_en",   64'(mem_en), 64'h0);
                check("d_dead_busy", 64'(busy),   64'h0);
            end
            cyc();
            set_req(3, 1, 1, (b == 20), 12'(12'h600 + b - 1), 32'(32'h600 + b - 1));
            settle();
            check("d_beat_en",   64'(mem_en),   64'h1);
            check("d_beat_addr", 64'(mem_addr), 64'(12'h600 + b - 1));
            if (b == 3) check("d_beat_cnt", 64'(dbg_beat_cnt), 64'h2);
        end
        cyc(); drop(3); settle();
        check("d_end_busy", 64'(busy), 64'h0);

        // MM stalls after 2 of 4 beats; FIR waits and gets the next grant
        set_req(2, 1, 1, 0, 12'h700, 32'h700);
        cyc(); settle();
        check("e_b1_grant", 64'(grant_id), 64'h2);
        check("e_b1_addr",  64'(mem_addr), 64'h700);
        cyc(); set_req(2, 1, 1, 0, 12'h701, 32'h701); settle();
        check("e_b2_addr", 64'(mem_addr), 64'h701);
        cyc(); drop(2); set_req(1, 1, 1, 1, 12'h800, 32'h800); settle();
        check("e_stall_ready", 64'(bus.req_ready), 64'h0);
        repeat (7) cyc();
        settle();
        check("e_stall8_busy",  64'(busy),     64'h1);
        check("e_stall8_grant", 64'(grant_id), 64'h2);
        cyc(); settle();
        check("e_rel_busy", 64'(busy),   64'h0);
        check("e_rel_en",   64'(mem_en), 64'h0);
        cyc(); settle();
        check("e_fir_grant", 64'(grant_id),      64'h1);
        check("e_fir_ready", 64'(bus.req_ready), 64'h2);
        cyc(); drop(1); settle();
        check("e_ptr", 64'(dbg_rr_ptr), 64'h2);

        // Reset one cycle after a host read is accepted: response discarded
        set_req(0, 1, 0, 1, 12'h010, 32'h0);
        cyc(); settle();
        check("f_rd_ready", 64'(bus.req_ready), 64'h1);
        cyc(); rst_n = 1'b0; drop(0); settle();
        check("f_rst_rsp", 64'(bus.rsp_valid), 64'h0);
        cyc(); rst_n = 1'b1; settle();
        check_reset_values("f");
        cyc(); settle();
        check("f_late_rsp", 64'(bus.rsp_valid), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
